// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word accept, LSB-first serial frame on Q/QV.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
//
// state | meaning
// IDLE  | RDY high, waiting for LD; Q/QV/DONE low
// SHIFT | frame in progress; Q carries bit cnt_q, DONE on the final frame bit
module piso_tx #(
   parameter int WIDTH = 8
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] D,
   input  logic             LD,
   output logic             RDY,
   output logic             Q,
   output logic             QV,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last;
   logic             bit_out;

`ifdef PISO_TX_PARITY_EN
   logic par_q, par_d;

   always_ff @(posedge C or negedge R) begin
      if (!R) par_q <= 1'b0;
      else    par_q <= par_d;
   end

   always_comb begin
      par_d = par_q;
      if (state_q == IDLE && LD) par_d = ^D;
   end

   // Data register is empty by the time the parity slot is reached.
   assign bit_out = (cnt_q == CW'(WIDTH)) ? par_q : sh_q[0];
`else
   assign bit_out = sh_q[0];
`endif

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end

   assign last = (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      RDY     = 1'b0;
      Q       = 1'b0;
      QV      = 1'b0;
      DONE    = 1'b0;
      case (state_q)
         IDLE: begin
            RDY = 1'b1;
            if (LD) begin
               sh_d    = D;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            Q     = bit_out;
            QV    = 1'b1;
            DONE  = last;
            sh_d  = {1'b0, sh_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: frame shape, loopback, back-to-back, busy ignore, reset abort, parity.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic       C;
   logic       R;
   logic [7:0] D;
   logic       LD;
   logic       RDY, Q, QV, DONE;
   logic [FRAME-1:0] rx = '0;

   int n_tests = 0;
   int n_fail  = 0;

   piso_tx #(.WIDTH(8)) dut (
      .C(C), .R(R), .D(D), .LD(LD),
      .RDY(RDY), .Q(Q), .QV(QV), .DONE(DONE)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   // Downstream right shift register, MSB-in, enabled by QV.
   always @(posedge C) if (QV) rx <= {Q, rx[FRAME-1:1]};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_idle_qv"},   32'(QV),   32'd0);
      chk({tag, "_idle_q"},    32'(Q),    32'd0);
      chk({tag, "_idle_rdy"},  32'(RDY),  32'd1);
      chk({tag, "_idle_done"}, 32'(DONE), 32'd0);
   endtask

   // Called with the DUT idle. pulse_at >= 0 drives LD=1,D=7E during that frame bit.
   task automatic run_frame(input logic [7:0] w, input logic exp_par, input int pulse_at,
                            input string tag);
      logic e;
      D  = w;
      LD = 1'b1;
      @(posedge C); #1;
      LD = 1'b0;
      D  = 8'h00;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge C);
         e = (i < 8) ? w[i] : exp_par;
         chk($sformatf("%s_q%0d", tag, i),    32'(Q),    32'(e));
         chk($sformatf("%s_qv%0d", tag, i),   32'(QV),   32'd1);
         chk($sformatf("%s_rdy%0d", tag, i),  32'(RDY),  32'd0);
         chk($sformatf("%s_done%0d", tag, i), 32'(DONE), 32'(i == FRAME - 1));
         if (i == pulse_at) begin
            LD = 1'b1;
            D  = 8'h7E;
         end
         @(posedge C); #1;
         LD = 1'b0;
      end
      @(negedge C);
      idle_chk(tag);
   endtask

   initial begin
      int dcnt;
      logic e;
      R  = 1'b0;
      LD = 1'b0;
      D  = 8'h00;
      #12;
      idle_chk("reset");
      @(negedge C);
      R = 1'b1;
      @(negedge C);
      idle_chk("post_rst");

      // A5 -> 1,0,1,0,0,1,0,1 ; parity of A5 is 0
      run_frame(8'hA5, 1'b0, -1, "basic");

      run_frame(8'h3C, 1'b0, -1, "loop");
      chk("loop_rx", 32'(rx[7:0]), 32'h3C);

      // Back-to-back with LD held high: FF frame, one idle cycle, 00 frame
      dcnt = 0;
      D  = 8'hFF;
      LD = 1'b1;
      @(posedge C); #1;
      D = 8'h00;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge C);
         e = (i < 8) ? 1'b1 : 1'b0;
         chk($sformatf("b2b_a_q%0d", i),  32'(Q),  32'(e));
         chk($sformatf("b2b_a_qv%0d", i), 32'(QV), 32'd1);
         if (DONE) dcnt++;
         @(posedge C); #1;
      end
      @(negedge C);
      idle_chk("b2b_gap");
      @(posedge C); #1;
      LD = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge C);
         chk($sformatf("b2b_b_q%0d", i),  32'(Q),  32'd0);
         chk($sformatf("b2b_b_qv%0d", i), 32'(QV), 32'd1);
         if (DONE) dcnt++;
         @(posedge C); #1;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge C);
         idle_chk($sformatf("b2b_end%0d", i));
         if (DONE) dcnt++;
      end
      chk("b2b_done_cnt", 32'(dcnt), 32'd2);

      // LD pulse at 3rd bit ignored; 81 -> 1,0,0,0,0,0,0,1 ; parity 0
      run_frame(8'h81, 1'b0, 2, "busy");
      @(negedge C);
      idle_chk("busy_after");

      // LD on the DONE cycle ignored as well
      run_frame(8'h5A, 1'b0, FRAME - 1, "ld_on_done");
      @(negedge C);
      idle_chk("ld_on_done_after");

      // Reset mid-frame after 4 bits of AA
      D  = 8'hAA;
      LD = 1'b1;
      @(posedge C); #1;
      LD = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge C);
         chk($sformatf("rst_q%0d", i), 32'(Q), 32'(i % 2));
         @(posedge C); #1;
      end
      @(negedge C); #1;
      R = 1'b0;
      #1;
      idle_chk("rst_async");
      @(posedge C); #2;
      R = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge C);
         idle_chk($sformatf("rst_norsm%0d", i));
      end
      run_frame(8'h55, 1'b0, -1, "after_rst");

`ifdef PISO_TX_PARITY_EN
      // 07 -> 1,1,1,0,0,0,0,0 then parity 1; 03 -> parity 0
      run_frame(8'h07, 1'b1, -1, "par07");
      run_frame(8'h03, 1'b0, -1, "par03");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
